// File: rtl/matriz_pkg.sv
// Shared constants, FSM state encoding and element slicing helper for the
// matriz_stream_out block and its index generator.
package matriz_pkg;

  localparam int ROWS    = 5;
  localparam int COLS    = 5;
  localparam int ELEM_W  = 8;
  localparam int N_ELEMS = ROWS * COLS;
  localparam int FLAT_W  = N_ELEMS * ELEM_W;
  localparam int IDX_W   = 5;
  localparam int ROW_W   = $clog2(ROWS);
  localparam int COL_W   = $clog2(COLS);
  localparam int CNT_W   = $clog2(N_ELEMS);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_RUN    = 2'd1,
    S_STREAM = 2'd2
  } state_e;

  // Element (r,c) lives at linear index r*COLS+c in the flat result vector.
  function automatic logic [ELEM_W-1:0] elem_slice(input logic [FLAT_W-1:0] flat,
                                                   input logic [IDX_W-1:0]  idx);
    return flat[idx*ELEM_W +: ELEM_W];
  endfunction

endpackage

// File: rtl/matriz_stream_out_if.sv
// Multiplier handshake plus result stream bundle. The block drives it through
// the master modport; the surrounding environment uses the slave modport.
interface matriz_stream_out_if;
  import matriz_pkg::*;

  logic                     op_start;
  logic                     mul_start;
  logic                     mul_done;
  logic                     mul_overflow;
  logic [FLAT_W-1:0]        mul_result;
  logic signed [ELEM_W-1:0] out_data;
  logic [IDX_W-1:0]         out_index;
  logic                     out_valid;
  logic                     out_ready;
  logic                     out_last;
  logic                     overflow;
  logic                     timeout_err;
  logic                     busy;

  modport master (
    input  op_start, mul_done, mul_overflow, mul_result, out_ready,
    output mul_start, out_data, out_index, out_valid, out_last,
           overflow, timeout_err, busy
  );

  modport slave (
    output op_start, mul_done, mul_overflow, mul_result, out_ready,
    input  mul_start, out_data, out_index, out_valid, out_last,
           overflow, timeout_err, busy
  );
endinterface

// File: rtl/matriz_index_gen.sv
// Row/column walker for the result stream. Row-major by default; defining
// MATRIZ_COL_MAJOR_EN walks column-major. next_index is always r*COLS+c.
module matriz_index_gen
  import matriz_pkg::*;
(
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             advance,
  output logic [IDX_W-1:0] next_index,
  output logic             next_last
);

  logic [ROW_W-1:0] row_q, row_d;
  logic [COL_W-1:0] col_q, col_d;
  logic [CNT_W-1:0] count_q, count_d;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      row_q   <= '0;
      col_q   <= '0;
      count_q <= '0;
    end else begin
      row_q   <= row_d;
      col_q   <= col_d;
      count_q <= count_d;
    end
  end

  // NOTE: every combinational output gets a default first so no path infers a latch.
  always_comb begin
    row_d   = row_q;
    col_d   = col_q;
    count_d = count_q;
    if (start) begin
      row_d   = '0;
      col_d   = '0;
      count_d = '0;
    end else if (advance) begin
      count_d = count_q + 1'b1;
`ifdef MATRIZ_COL_MAJOR_EN
      if (row_q == ROW_W'(ROWS - 1)) begin
        row_d = '0;
        col_d = col_q + 1'b1;
      end else begin
        row_d = row_q + 1'b1;
      end
`else
      if (col_q == COL_W'(COLS - 1)) begin
        col_d = '0;
        row_d = row_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end
`endif
    end
  end

  // Look-ahead outputs let the parent register the next element on the same edge.
  assign next_index = IDX_W'(row_d * COLS) + IDX_W'(col_d);
  assign next_last  = (count_d == CNT_W'(N_ELEMS - 1));

endmodule

// File: rtl/matriz_stream_out.sv
// Starts a matrix multiplier, captures its flat result and streams the elements
// out over a valid/ready handshake. MATRIZ_COL_MAJOR_EN selects column-major order.
module matriz_stream_out #(
  parameter int ROWS    = matriz_pkg::ROWS,
  parameter int COLS    = matriz_pkg::COLS,
  parameter int ELEM_W  = matriz_pkg::ELEM_W,
  parameter int TIMEOUT = 15
) (
  input logic                clock,
  input logic                reset,
  matriz_stream_out_if.master io
);

  localparam int FLAT_W = ROWS * COLS * ELEM_W;
  localparam int TMR_W  = $clog2(TIMEOUT + 1);
  localparam int IDX_W  = matriz_pkg::IDX_W;

  matriz_pkg::state_e state_q, state_d;
  logic               mul_start_q, mul_start_d;
  logic               overflow_q, overflow_d;
  logic               timeout_err_q, timeout_err_d;
  logic               out_valid_q, out_valid_d;
  logic               out_last_q, out_last_d;
  logic [ELEM_W-1:0]  out_data_q, out_data_d;
  logic [IDX_W-1:0]   out_index_q, out_index_d;
  logic [TMR_W-1:0]   tmr_q, tmr_d;
  logic [FLAT_W-1:0]  result_q, result_d;

  logic               gen_start, gen_advance, next_last;
  logic [IDX_W-1:0]   next_index;

  assign gen_start   = (state_q == matriz_pkg::S_RUN) && io.mul_done;
  assign gen_advance = (state_q == matriz_pkg::S_STREAM) && io.out_ready && !out_last_q;

  matriz_index_gen u_index_gen (
    .clock      (clock),
    .reset      (reset),
    .start      (gen_start),
    .advance    (gen_advance),
    .next_index (next_index),
    .next_last  (next_last)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q       <= matriz_pkg::S_IDLE;
      mul_start_q   <= 1'b0;
      overflow_q    <= 1'b0;
      timeout_err_q <= 1'b0;
      out_valid_q   <= 1'b0;
      out_last_q    <= 1'b0;
      out_data_q    <= '0;
      out_index_q   <= '0;
      tmr_q         <= '0;
    end else begin
      state_q       <= state_d;
      mul_start_q   <= mul_start_d;
      overflow_q    <= overflow_d;
      timeout_err_q <= timeout_err_d;
      out_valid_q   <= out_valid_d;
      out_last_q    <= out_last_d;
      out_data_q    <= out_data_d;
      out_index_q   <= out_index_d;
      tmr_q         <= tmr_d;
    end
  end

  // NOTE: the result buffer is pure data, written before it is ever read, so it
  // carries no reset.
  always_ff @(posedge clock) begin
    result_q <= result_d;
  end

  always_comb begin
    state_d       = state_q;
    mul_start_d   = mul_start_q;
    overflow_d    = overflow_q;
    timeout_err_d = 1'b0;
    out_valid_d   = out_valid_q;
    out_last_d    = out_last_q;
    out_data_d    = out_data_q;
    out_index_d   = out_index_q;
    tmr_d         = tmr_q;
    result_d      = result_q;

    unique case (state_q)
      matriz_pkg::S_IDLE: begin
        if (io.op_start) begin
          state_d     = matriz_pkg::S_RUN;
          mul_start_d = 1'b1;
          overflow_d  = 1'b0;
          tmr_d       = '0;
        end
      end

      matriz_pkg::S_RUN: begin
        overflow_d = overflow_q | io.mul_overflow;
        if (gen_start) begin
          // First element comes straight from the bus; the buffer loads on the same edge.
          result_d    = io.mul_result;
          mul_start_d = 1'b0;
          state_d     = matriz_pkg::S_STREAM;
          out_valid_d = 1'b1;
          out_index_d = next_index;
          out_last_d  = next_last;
          out_data_d  = matriz_pkg::elem_slice(io.mul_result, next_index);
        end else if (tmr_q == TMR_W'(TIMEOUT - 1)) begin
          timeout_err_d = 1'b1;
          mul_start_d   = 1'b0;
          state_d       = matriz_pkg::S_IDLE;
          tmr_d         = '0;
        end else begin
          tmr_d = tmr_q + 1'b1;
        end
      end

      matriz_pkg::S_STREAM: begin
        if (io.out_ready) begin
          if (out_last_q) begin
            state_d     = matriz_pkg::S_IDLE;
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
          end else begin
            out_index_d = next_index;
            out_last_d  = next_last;
            out_data_d  = matriz_pkg::elem_slice(result_q, next_index);
          end
        end
      end

      default: state_d = matriz_pkg::S_IDLE;
    endcase
  end

  assign io.mul_start   = mul_start_q;
  assign io.overflow    = overflow_q;
  assign io.timeout_err = timeout_err_q;
  assign io.out_valid   = out_valid_q;
  assign io.out_last    = out_last_q;
  assign io.out_data    = out_data_q;
  assign io.out_index   = out_index_q;
  assign io.busy        = (state_q != matriz_pkg::S_IDLE);

endmodule
